zbus_ports: RTL

ZBUS_PORTS -- requirements
Module: zbus_ports

---
 rtl/zbus_ports.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/zbus_ports.sv
// zbus_ports: Z80 I/O port window bridged to a req/ack backend.
// Ports: fclk/rst, Z80 bus (za, zd_in, zd_out, zd_oe, strobes,
//   ziorqge, zwait_n), backend (req*, ack, ack_rdata), err.
module zbus_ports #(
  parameter logic [7:0] BASE_ADDR = 8'hAB,
  parameter int         ADDR_W    = 2,
  parameter int         SYNC      = 2,
  parameter int         TIMEOUT   = 255
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic [15:0]       za,
  input  logic [7:0]        zd_in,
  output logic [7:0]        zd_out,
  output logic              zd_oe,
  input  logic              ziorq_n,
  input  logic              zrd_n,
  input  logic              zwr_n,
  output logic              ziorqge,
  output logic              zwait_n,
  output logic              req,
  output logic              req_wr,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_wdata,
  input  logic              ack,
  input  logic [7:0]        ack_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [SYNC-1:0] iorq_sync_q, iorq_sync_d;
  logic [SYNC-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC-1:0] wr_sync_q, wr_sync_d;

  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [7:0]        req_wdata_q, req_wdata_d;
  logic [7:0]        zd_out_q, zd_out_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic iorq_s, rd_s, wr_s;
  logic hit, raw_hit;
  logic unused_za;

  // Upper port-select bits beyond ADDR_W are don't-care.
  assign unused_za = ^za[14:8];

  assign iorq_s = iorq_sync_q[SYNC-1];
  assign rd_s   = rd_sync_q[SYNC-1];
  assign wr_s   = wr_sync_q[SYNC-1];

  assign ziorqge = (za[7:0] == BASE_ADDR);
  assign hit     = ziorqge && za[15];
  assign raw_hit = hit && !ziorq_n && (!zrd_n || !zwr_n);

  always_comb begin
    iorq_sync_d = {iorq_sync_q[SYNC-2:0], ziorq_n};
    rd_sync_d   = {rd_sync_q[SYNC-2:0], zrd_n};
    wr_sync_d   = {wr_sync_q[SYNC-2:0], zwr_n};
  end

  always_comb begin
    state_d     = state_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    zd_out_d    = zd_out_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!iorq_s && (!rd_s || !wr_s) && hit) begin
          state_d     = S_REQ;
          // Write wins if both strobes are seen low.
          req_wr_d    = !wr_s;
          req_addr_d  = za[8 +: ADDR_W];
          req_wdata_d = zd_in;
          cnt_d       = 8'd0;
        end
      end
      S_REQ: begin
        if (ack) begin
          state_d = S_DONE;
          if (!req_wr_q) zd_out_d = ack_rdata;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TO_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            if (!req_wr_q) zd_out_d = 8'hFF;
          end
        end
      end
      S_DONE: begin
        if (iorq_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      iorq_sync_q <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= 8'h00;
      zd_out_q    <= 8'hFF;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      iorq_sync_q <= iorq_sync_d;
      rd_sync_q   <= rd_sync_d;
      wr_sync_q   <= wr_sync_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      zd_out_q    <= zd_out_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req       = (state_q == S_REQ);
  assign req_wr    = req_wr_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign zd_out    = zd_out_q;
  assign err       = err_q;

  // WAIT goes low straight from the raw strobes so the Z80
  // is held before the synchronisers catch up.
  assign zwait_n = !((raw_hit && state_q == S_IDLE) ||
                     state_q == S_REQ);

  assign zd_oe = !ziorq_n && !zrd_n && hit &&
                 (state_q == S_DONE);

endmodule
